// File: rtl/msrv32_pc_sequencer.sv
// ---------------------------------------------------------------------------
// msrv32_pc_sequencer
// Computes the next program counter for the PC register and drives the
// instruction-fetch request. It arbitrates between PC+4, branch/jump
// redirect, trap entry and MRET return, and it holds the PC during a fetch
// wait or a pipeline stall. Each redirect is followed by a one-cycle
// flush bubble.
//
// Optional feature macro: MSRV32_PC_MISALIGN_CHK_EN
//   When this macro is defined, a branch to a target that is not word aligned
//   is suppressed and misaligned_out pulses for one cycle.
//   When it is undefined, branch targets are used as given and
//   misaligned_out is always 0.
//
// Ports
//   ms_riscv32_mp_clk_in  : clock, rising edge
//   ms_riscv32_mp_rst_in  : synchronous active-low reset
//   pc_in                 : current PC (from the PC register)
//   branch_taken_in/_target_in : redirect request and target
//   trap_taken_in/trap_vector_in : trap entry request and handler address
//   mret_in/epc_in        : return-from-trap request and return address
//   stall_in              : downstream pipeline stall
//   imem_ack_in           : instruction memory returned data
//   imem_req_out          : fetch request (combinational)
//   imem_addr_out         : fetch address, always pc_in
//   pc_mux_out            : next PC (combinational, captured every cycle)
//   flush_out             : registered one-cycle flush pulse
//   misaligned_out        : registered misaligned-branch pulse
//   seq_state_out         : current FSM state
// ---------------------------------------------------------------------------
module msrv32_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter logic [31:0] TRAP_ALIGN_MASK = 32'hFFFF_FFFC
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] pc_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        stall_in,
    input  logic        imem_ack_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] pc_mux_out,
    output logic        flush_out,
    output logic        misaligned_out,
    output logic [1:0]  seq_state_out
);

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } seq_state_e;

    seq_state_e        state_q, state_d;
    logic              flush_q, flush_d;
    logic              misaligned_q, misaligned_d;
    logic [PC_W-1:0]   pc_seq;
    logic [PC_W-1:0]   pc_trap;
    logic [PC_W-1:0]   pc_except;
    logic              branch_bad;

    // Candidate next-PC values
    assign pc_seq    = pc_in + PC_W'(4);
    assign pc_trap   = trap_vector_in & TRAP_ALIGN_MASK;
    // A trap has priority over mret when both are requested
    assign pc_except = trap_taken_in ? pc_trap : (epc_in & TRAP_ALIGN_MASK);

`ifdef MSRV32_PC_MISALIGN_CHK_EN
    assign branch_bad = (branch_target_in[1:0] != 2'b00);
`else
    assign branch_bad = 1'b0;
`endif

    // State and pulse registers
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q      <= S_RESET;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state and next-PC select
    always_comb begin
        state_d      = state_q;
        flush_d      = 1'b0;
        misaligned_d = 1'b0;
        pc_mux_out   = pc_in;
        imem_req_out = 1'b0;

        case (state_q)
            S_RESET: begin
                pc_mux_out = RESET_VECTOR;
                state_d    = S_FETCH;
            end

            S_FETCH: begin
                imem_req_out = 1'b1;
                if (trap_taken_in || mret_in) begin
                    pc_mux_out = pc_except;
                    state_d    = S_FLUSH;
                    flush_d    = 1'b1;
                end else if (!imem_ack_in) begin
                    state_d = S_FETCH;
                end else if (stall_in) begin
                    state_d = S_STALL;
                end else if (branch_taken_in) begin
                    if (branch_bad) begin
                        // Misaligned target: hold PC and let the trap unit respond
                        misaligned_d = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        pc_mux_out = branch_target_in;
                        state_d    = S_FLUSH;
                        flush_d    = 1'b1;
                    end
                end else begin
                    pc_mux_out = pc_seq;
                    state_d    = S_FETCH;
                end
            end

            S_STALL: begin
                if (trap_taken_in || mret_in) begin
                    pc_mux_out = pc_except;
                    state_d    = S_FLUSH;
                    flush_d    = 1'b1;
                end else if (stall_in) begin
                    state_d = S_STALL;
                end else if (branch_taken_in) begin
                    if (branch_bad) begin
                        misaligned_d = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        pc_mux_out = branch_target_in;
                        state_d    = S_FLUSH;
                        flush_d    = 1'b1;
                    end
                end else begin
                    pc_mux_out = pc_seq;
                    state_d    = S_FETCH;
                end
            end

            S_FLUSH: begin
                // Only a trap can re-redirect out of the bubble
                if (trap_taken_in) begin
                    pc_mux_out = pc_trap;
                    state_d    = S_FLUSH;
                    flush_d    = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign imem_addr_out  = pc_in;
    assign flush_out      = flush_q;
    assign misaligned_out = misaligned_q;
    assign seq_state_out  = 2'(state_q);

endmodule

// File: doc/msrv32_pc_sequencer.md
Name: msrv32_pc_sequencer

Overview:
- Sequencing controller for the program-counter register.
- Generates the next-PC value on `pc_mux_out`, which feeds the PC register's `pc_mux_in`, and drives the instruction-fetch request handshake.
- Arbitrates between PC+4 advance, branch/jump redirect, trap entry and MRET return; holds the PC on fetch wait or pipeline stall.
- Issues a one-cycle flush bubble after every redirect.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded after reset release.
- TRAP_ALIGN_MASK, 32'hFFFF_FFFC, AND-mask applied to trap_vector_in and epc_in.

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock, rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-low.
- pc_in  input  32  current PC, from the PC register's pc_out.
- branch_taken_in  input  1  branch/JAL/JALR redirect request.
- branch_target_in  input  32  redirect target.
- trap_taken_in  input  1  trap entry request.
- trap_vector_in  input  32  trap handler address (mtvec-derived).
- mret_in  input  1  return-from-trap request.
- epc_in  input  32  return address (mepc).
- stall_in  input  1  downstream pipeline stall.
- imem_ack_in  input  1  instruction memory has returned data for imem_addr_out.
- imem_req_out  output  1  fetch request.
- imem_addr_out  output  32  fetch address; always equals pc_in.
- pc_mux_out  output  32  next PC; the PC register captures it every cycle.
- flush_out  output  1  kill the in-flight instruction; registered, one-cycle pulse.
- misaligned_out  output  1  branch target misaligned; registered pulse. Present only with the optional feature.
- seq_state_out  output  2  current FSM state, for debug.

Behaviour:
- All state updates occur on the rising clock edge.
- When ms_riscv32_mp_rst_in == 0 at an edge:
  - state <= S_RESET; flush_out <= 0; misaligned_out <= 0.
- Combinational outputs:
  - In S_RESET: pc_mux_out = RESET_VECTOR; imem_req_out = 0.
- States (encoding): S_RESET=2'd0, S_FETCH=2'd1, S_STALL=2'd2, S_FLUSH=2'd3.
- Next-PC select, strict priority: trap > mret > branch > sequential.
  - trap: pc_mux_out = trap_vector_in & TRAP_ALIGN_MASK.
  - mret: pc_mux_out = epc_in & TRAP_ALIGN_MASK.
  - branch: pc_mux_out = branch_target_in.
  - sequential: pc_mux_out = pc_in + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - When the PC is held: pc_mux_out = pc_in.
- S_RESET:
  - Outputs as above.
  - Next state: S_FETCH unconditionally once reset is deasserted.
  - Latency: the PC equals RESET_VECTOR one edge after release; the first fetch request is seen in the following cycle.
- S_FETCH:
  - imem_req_out = 1.
  - trap_taken_in or mret_in asserted: redirect immediately, without waiting for ack; next state S_FLUSH; flush_out <= 1.
  - Else imem_ack_in == 0: hold PC; stay in S_FETCH.
  - Else imem_ack_in == 1 and stall_in == 1: hold PC; go to S_STALL.
  - Else imem_ack_in == 1 and stall_in == 0:
    - branch_taken_in: redirect; go to S_FLUSH; flush_out <= 1.
    - otherwise: pc_mux_out = pc_in + 4; stay in S_FETCH.
- S_STALL:
  - imem_req_out = 0.
  - trap_taken_in or mret_in: redirect; go to S_FLUSH; flush_out <= 1.
  - Else stall_in == 1: hold PC.
  - Else: apply the branch/sequential select as in S_FETCH with ack; branch goes to S_FLUSH, sequential goes to S_FETCH.
- S_FLUSH:
  - imem_req_out = 0; hold PC.
  - flush_out is high during this cycle.
  - A trap_taken_in here overrides: redirect again and stay in S_FLUSH for one more cycle.
  - Otherwise go to S_FETCH.
- Simultaneous events:
  - A trap wins over mret and branch in the same cycle.
  - branch_taken_in is ignored unless imem_ack_in is high (S_FETCH) or the state is S_STALL.
- flush_out:
  - Registered; exactly one cycle per redirect.
  - Back-to-back redirects give back-to-back pulses.
- Reset mid-operation: the FSM returns to S_RESET at the next edge regardless of state; any pending redirect is discarded.

Optional Feature:
- Macro: MSRV32_PC_MISALIGN_CHK_EN.
- Defined:
  - A branch redirect with branch_target_in[1:0] != 2'b00 is suppressed: PC held, no flush.
  - misaligned_out <= 1 for one cycle.
  - The state follows the sequential path but does not advance; the trap unit is expected to respond with trap_taken_in.
- Undefined:
  - Targets are used unmodified; misaligned_out is tied to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release. Required: pc_mux_out=0x0 during reset; state S_FETCH next cycle; imem_req_out=1; PC sequence 0x0, 0x4, 0x8 with imem_ack_in held at 1.
- Fetch wait: imem_ack_in=0 for 4 cycles at pc_in=0x100. Required: pc_mux_out=0x100 and imem_req_out=1 throughout; advances to 0x104 on the ack cycle.
- Branch: pc_in=0x200, ack=1, branch_taken_in=1, target=0x80. Required: pc_mux_out=0x80; flush_out=1 in the next cycle; imem_req_out=0 in S_FLUSH; fetch resumes at 0x80.
- Priority: trap_taken_in, mret_in and branch_taken_in all 1; trap_vector_in=0x1003; epc_in=0x500. Required: pc_mux_out=0x1000; single flush pulse.
- Stall/wrap: pc_in=0xFFFF_FFFC, ack=1, stall_in=1 for 2 cycles, then 0. Required: PC held 2 cycles (S_STALL); then pc_mux_out=0x0000_0000.
- With MSRV32_PC_MISALIGN_CHK_EN defined: branch to 0x0000_0102 from PC 0x300. Required: misaligned_out=1 for one cycle; pc_mux_out=0x300; flush_out=0.
